// File: rtl/char_writer_if.sv
// char_writer_if: character stream handshake (ch_data/ch_valid/ch_ready), char RAM write port (addr/din/ram_en) and busy status
interface char_writer_if;
  logic [7:0] ch_data;
  logic ch_valid;
  logic ch_ready;
  logic [10:0] addr;
  logic [7:0] din;
  logic ram_en;
  logic busy;
  modport master (output ch_data, ch_valid, input ch_ready, addr, din, ram_en, busy);
  modport slave (input ch_data, ch_valid, output ch_ready, addr, din, ram_en, busy);
endinterface

// File: rtl/char_writer.sv
// char_writer: cursor-tracking text writer into char RAM; ports clk, rst, bus (char_writer_if.slave); CHAR_WRITER_CLEAR_EN enables form-feed screen clear
module char_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input logic clk,
  input logic rst,
  char_writer_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [10:0] COLS_W = 11'(COLS);
  localparam logic [10:0] LAST = 11'(COLS * ROWS - 1);
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n, row_inc;
  logic [10:0] addr, addr_n, cur;
  logic [7:0] din, din_n;
  logic en, en_n, rdy, xfer, clearing, clr_go, clr_end;
`ifdef CHAR_WRITER_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  assign clearing = state == CLEAR;
  assign clr_go = xfer && bus.ch_data == 8'h0C;
  assign clr_end = clearing && addr == LAST;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb state_n = clr_go ? CLEAR : clr_end ? IDLE : state;
`else
  assign clearing = 1'b0;
  assign clr_go = 1'b0;
  assign clr_end = 1'b0;
`endif
  assign xfer = bus.ch_valid && bus.ch_ready;
  always_comb begin
    col_n = col;
    row_n = row;
    addr_n = addr;
    din_n = din;
    en_n = 1'b0;
    row_inc = row == ROW_MAX ? '0 : row + 1'b1;
    cur = 11'(row) * COLS_W + 11'(col);
    if (clearing) begin
      en_n = !clr_end;
      addr_n = clr_end ? addr : addr + 1'b1;
      din_n = 8'h20;
      col_n = '0;
      row_n = '0;
    end else if (xfer) begin
      if (bus.ch_data inside {[8'h20:8'h7E]}) begin
        en_n = 1'b1;
        addr_n = cur;
        din_n = bus.ch_data;
        col_n = col == COL_MAX ? '0 : col + 1'b1;
        row_n = col == COL_MAX ? row_inc : row;
      end else if (bus.ch_data == 8'h0D) begin
        col_n = '0;
      end else if (bus.ch_data == 8'h0A) begin
        row_n = row_inc;
      end else if (bus.ch_data == 8'h08 && col != '0) begin
        col_n = col - 1'b1;
        en_n = 1'b1;
        addr_n = cur - 11'd1;
        din_n = 8'h20;
      end else if (clr_go) begin
        en_n = 1'b1;
        addr_n = '0;
        din_n = 8'h20;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      addr <= '0;
      din <= '0;
      en <= 1'b0;
      rdy <= 1'b0;
    end else begin
      col <= col_n;
      row <= row_n;
      addr <= addr_n;
      din <= din_n;
      en <= en_n;
      rdy <= 1'b1;
    end
  end
  assign bus.ch_ready = rdy && !clearing;
  assign bus.addr = addr;
  assign bus.din = din;
  assign bus.ram_en = en;
  assign bus.busy = clearing;
endmodule

// File: tb/tb_char_writer.sv
// tb_char_writer: self-checking bench for char_writer with write scoreboard and vector table
`timescale 1ns/1ps
module tb_char_writer;
  typedef struct { logic [10:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] ch; logic wr; logic [10:0] a; logic [7:0] d; } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nerr = 0;
  wr_t q[$];
  vec_t tbl[22];
  char_writer_if bus();
  char_writer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst && bus.ram_en !== 1'b0) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected write: ram_en %b addr %0d din %0h, expected no write", bus.ram_en, bus.addr, bus.din);
      end else begin
        e = q.pop_front();
        chk("write addr", 32'(bus.addr), 32'(e.a));
        chk("write din", 32'(bus.din), 32'(e.d));
      end
    end
  end
  task automatic put(input logic [10:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] c);
    bus.ch_data = c;
    bus.ch_valid = 1'b1;
    @(negedge clk);
    chk("ch_ready on send", 32'(bus.ch_ready), 1);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.ch_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    idle(3);
    chk(name, q.size(), 0);
    q.delete();
  endtask
  task automatic do_reset;
    rst = 1'b1;
    bus.ch_valid = 1'b0;
    bus.ch_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ch_ready", 32'(bus.ch_ready), 0);
    chk("reset ram_en", 32'(bus.ram_en), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset addr", 32'(bus.addr), 0);
    chk("reset din", 32'(bus.din), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ch_ready after reset", 32'(bus.ch_ready), 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, bad;
    bus.ch_valid = 1'b0;
    bus.ch_data = 8'h00;
    tbl = '{
      '{8'h41, 1'b1, 11'd0, 8'h41}, '{8'h42, 1'b1, 11'd1, 8'h42},
      '{8'h0D, 1'b0, 11'd0, 8'h00}, '{8'h0A, 1'b0, 11'd0, 8'h00},
      '{8'h43, 1'b1, 11'd80, 8'h43}, '{8'h08, 1'b1, 11'd80, 8'h20},
      '{8'h08, 1'b0, 11'd0, 8'h00}, '{8'h07, 1'b0, 11'd0, 8'h00},
      '{8'h7F, 1'b0, 11'd0, 8'h00}, '{8'h20, 1'b1, 11'd80, 8'h20},
      '{8'h7E, 1'b1, 11'd81, 8'h7E}, '{8'h1F, 1'b0, 11'd0, 8'h00},
      '{8'h0D, 1'b0, 11'd0, 8'h00}, '{8'h0A, 1'b0, 11'd0, 8'h00},
      '{8'h61, 1'b1, 11'd160, 8'h61}, '{8'h62, 1'b1, 11'd161, 8'h62},
      '{8'h63, 1'b1, 11'd162, 8'h63}, '{8'h64, 1'b1, 11'd163, 8'h64},
      '{8'h65, 1'b1, 11'd164, 8'h65}, '{8'h08, 1'b1, 11'd164, 8'h20},
      '{8'h80, 1'b0, 11'd0, 8'h00}, '{8'h66, 1'b1, 11'd164, 8'h66}
    };
    do_reset;
    foreach (tbl[i]) begin
      if (tbl[i].wr) put(tbl[i].a, tbl[i].d);
      send(tbl[i].ch);
    end
    drain("table queue empty");
`ifndef CHAR_WRITER_CLEAR_EN
    send(8'h0C);
    idle(2);
    chk("form feed busy", 32'(bus.busy), 0);
    put(11'd165, 8'h67);
    send(8'h67);
    drain("form feed ignored queue");
`endif
    do_reset;
    for (int i = 0; i < 81; i++) begin
      put(11'(i), 8'h21 + 8'(i));
      send(8'h21 + 8'(i));
    end
    send(8'h0D);
    put(11'd80, 8'h5A);
    send(8'h5A);
    drain("81 bytes queue");
    do_reset;
    for (int i = 0; i < 24; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) begin
      put(11'(1920 + i), 8'h2E);
      send(8'h2E);
    end
    put(11'd1999, 8'h42);
    send(8'h42);
    put(11'd0, 8'h43);
    send(8'h43);
    send(8'h0D);
    send(8'h0A);
    put(11'd80, 8'h44);
    send(8'h44);
    drain("wrap queue");
`ifdef CHAR_WRITER_CLEAR_EN
    do_reset;
    put(11'd0, 8'h58);
    send(8'h58);
    for (int i = 0; i < 2000; i++) put(11'(i), 8'h20);
    put(11'd0, 8'h43);
    send(8'h0C);
    bus.ch_data = 8'h43;
    n = 0;
    bad = 0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (bus.ch_ready === 1'b1) break;
      n++;
      if (bus.busy !== 1'b1 || bus.ram_en !== 1'b1) bad++;
    end
    chk("clear cycle count", n, 2000);
    chk("clear busy/ram_en lapses", bad, 0);
    chk("ch_ready after clear", 32'(bus.ch_ready), 1);
    @(posedge clk);
    #1;
    drain("clear queue");
    do_reset;
    put(11'd0, 8'h59);
    send(8'h59);
    for (int i = 0; i <= 500; i++) put(11'(i), 8'h20);
    send(8'h0C);
    bus.ch_valid = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.ram_en === 1'b1 && bus.addr == 11'd500) break;
    end
    chk("abort point addr", 32'(bus.addr), 500);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort ram_en", 32'(bus.ram_en), 0);
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort ch_ready", 32'(bus.ch_ready), 0);
    chk("abort queue", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("busy after abort", 32'(bus.busy), 0);
    put(11'd0, 8'h46);
    send(8'h46);
    drain("abort queue empty");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
